int_replay_queue: RTL and testbench



---
 rtl/int_replay_queue_pkg.sv | 38 +++
 rtl/replay_flush_filter.sv | 17 +
 rtl/int_replay_queue.sv | 169 ++++++++++++++++
 tb/tb_int_replay_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_replay_queue_pkg.sv
// Shared types for the integer replay queue.
// Entry layout, index/count widths and the modular flush-range test.
package int_replay_queue_pkg;

  localparam int RQ_ISSUE_W      = 2;
  localparam int RQ_DEPTH        = 8;
  localparam int RQ_ENTRY_W      = 64;
  localparam int RQ_AL_PTR_W     = 6;
  localparam int RQ_REPLAY_DELAY = 2;
  localparam int REPLAY_DELAY_W  = 3;
  localparam int RQ_IDX_W        = $clog2(RQ_DEPTH);
  localparam int RQ_CNT_W        = RQ_IDX_W + 1;

  typedef logic [RQ_IDX_W-1:0]    rq_index_t;
  typedef logic [RQ_CNT_W-1:0]    rq_count_t;
  typedef logic [RQ_AL_PTR_W-1:0] al_ptr_t;

  typedef struct packed {
    logic                      valid;
    logic [REPLAY_DELAY_W-1:0] delay;
    al_ptr_t                   al_ptr;
    logic [RQ_ENTRY_W-1:0]     payload;
  } rq_entry_t;

  // Half-open [head, tail) on the wrapping active-list ring.
  function automatic logic in_flush_range(
    input al_ptr_t ptr,
    input al_ptr_t head,
    input al_ptr_t tail
  );
    al_ptr_t off;
    al_ptr_t span;
    off  = ptr - head;
    span = tail - head;
    return off < span;
  endfunction

endpackage

// File: rtl/replay_flush_filter.sv
// Kills one valid bit when its active-list pointer
// falls inside the selective-flush range.
module replay_flush_filter
  import int_replay_queue_pkg::*;
(
  input  logic    valid,
  input  al_ptr_t al_ptr,
  input  logic    flush_valid,
  input  al_ptr_t flush_head_ptr,
  input  al_ptr_t flush_tail_ptr,
  output logic    live
);

  assign live = valid & ~(flush_valid &
    in_flush_range(al_ptr, flush_head_ptr, flush_tail_ptr));

endmodule

// File: rtl/int_replay_queue.sv
// Replay queue for integer ops recorded with invalid operands.
// Holds each op for a fixed delay, then replays in record order.
module int_replay_queue
  import int_replay_queue_pkg::*;
#(
  parameter int INT_ISSUE_WIDTH = RQ_ISSUE_W,
  parameter int DEPTH           = RQ_DEPTH,
  parameter int ENTRY_W         = RQ_ENTRY_W,
  parameter int AL_PTR_W        = RQ_AL_PTR_W,
  parameter int REPLAY_DELAY    = RQ_REPLAY_DELAY
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                stall,
  input  logic                                clear,
  input  logic [INT_ISSUE_WIDTH-1:0]          rec_valid,
  input  logic [INT_ISSUE_WIDTH*ENTRY_W-1:0]  rec_data,
  input  logic [INT_ISSUE_WIDTH*AL_PTR_W-1:0] rec_al_ptr,
  input  logic                                flush_valid,
  input  logic [AL_PTR_W-1:0]                 flush_head_ptr,
  input  logic [AL_PTR_W-1:0]                 flush_tail_ptr,
  input  logic                                rpl_ready,
  output logic [INT_ISSUE_WIDTH-1:0]          rpl_valid,
  output logic [INT_ISSUE_WIDTH*ENTRY_W-1:0]  rpl_data,
  output logic                                full,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                overflow
);

  localparam int W = INT_ISSUE_WIDTH;
  localparam logic [REPLAY_DELAY_W-1:0] DLY =
    REPLAY_DELAY_W'(REPLAY_DELAY);

  rq_entry_t ent_q [DEPTH];
  rq_entry_t ent_n [DEPTH];
  rq_index_t head_q;
  rq_index_t tail_q;
  rq_count_t count_q;
  logic      overflow_q;

  logic [DEPTH-1:0] live;
  logic [W-1:0]     rec_live;
  rq_count_t        pop;
  rq_count_t        acc;
  rq_count_t        free;
  logic             ovf;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    replay_flush_filter u_filt (
      .valid          (ent_q[i].valid),
      .al_ptr         (ent_q[i].al_ptr),
      .flush_valid    (flush_valid),
      .flush_head_ptr (flush_head_ptr),
      .flush_tail_ptr (flush_tail_ptr),
      .live           (live[i])
    );
  end

  for (genvar l = 0; l < W; l++) begin : g_rec
    replay_flush_filter u_filt (
      .valid          (rec_valid[l]),
      .al_ptr         (rec_al_ptr[l*AL_PTR_W +: AL_PTR_W]),
      .flush_valid    (flush_valid),
      .flush_head_ptr (flush_head_ptr),
      .flush_tail_ptr (flush_tail_ptr),
      .live           (rec_live[l])
    );
  end

  // Eligibility is a prefix chain from head; no entry is bypassed.
  always_comb begin
    logic      ok;
    rq_index_t idx;
    rpl_valid = '0;
    rpl_data  = '0;
    ok        = 1'b1;
    for (int k = 0; k < W; k++) begin
      idx = head_q + rq_index_t'(k);
      ok  = ok & live[idx] & (ent_q[idx].delay == '0);
      rpl_valid[k] = ok;
      if (ok) rpl_data[k*ENTRY_W +: ENTRY_W] = ent_q[idx].payload;
    end
  end

  always_comb begin
    logic      run;
    rq_index_t idx;
    pop = '0;
    run = 1'b1;
    idx = head_q;
    if (!stall && !clear) begin
      if (rpl_ready && rpl_valid[0]) begin
        for (int k = 0; k < W; k++)
          if (rpl_valid[k]) pop = pop + 1'b1;
      end else begin
        for (int k = 0; k < W; k++) begin
          idx = head_q + rq_index_t'(k);
          if (run && rq_count_t'(k) < count_q && !ent_q[idx].valid)
            pop = pop + 1'b1;
          else
            run = 1'b0;
        end
      end
    end
  end

  assign free = rq_count_t'(DEPTH) - count_q + pop;

  always_comb begin
    rq_index_t idx;
    acc = '0;
    ovf = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = ent_q[i];
      ent_n[i].valid = live[i];
      if (!stall && ent_q[i].valid && ent_q[i].delay != '0)
        ent_n[i].delay = ent_q[i].delay - 1'b1;
    end
    for (int k = 0; k < W; k++) begin
      idx = head_q + rq_index_t'(k);
      if (rq_count_t'(k) < pop) ent_n[idx].valid = 1'b0;
    end
    if (!stall && !clear) begin
      for (int l = 0; l < W; l++) begin
        if (rec_live[l]) begin
          if (acc < free) begin
            idx = tail_q + acc[RQ_IDX_W-1:0];
            ent_n[idx].valid   = 1'b1;
            ent_n[idx].delay   = DLY;
            ent_n[idx].al_ptr  = rec_al_ptr[l*AL_PTR_W +: AL_PTR_W];
            ent_n[idx].payload = rec_data[l*ENTRY_W +: ENTRY_W];
            acc = acc + 1'b1;
          end else begin
            ovf = 1'b1;
          end
        end
      end
    end
    if (clear)
      for (int i = 0; i < DEPTH; i++) ent_n[i].valid = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ent_q <= ent_n;
      if (clear) begin
        head_q  <= tail_q;
        count_q <= '0;
      end else if (!stall) begin
        head_q  <= head_q + pop[RQ_IDX_W-1:0];
        tail_q  <= tail_q + acc[RQ_IDX_W-1:0];
        count_q <= count_q - pop + acc;
        if (ovf) overflow_q <= 1'b1;
      end
    end
  end

  assign full     = (rq_count_t'(DEPTH) - count_q) < rq_count_t'(W);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_int_replay_queue.sv
// Directed bench for int_replay_queue with a scoreboard
// of expected replay payloads checked by a monitor.
module tb_int_replay_queue;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic         clear;
  logic [1:0]   rec_valid;
  logic [127:0] rec_data;
  logic [11:0]  rec_al_ptr;
  logic         flush_valid;
  logic [5:0]   flush_head_ptr;
  logic [5:0]   flush_tail_ptr;
  logic         rpl_ready;
  logic [1:0]   rpl_valid;
  logic [127:0] rpl_data;
  logic         full;
  logic [3:0]   count;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  int_replay_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .clear          (clear),
    .rec_valid      (rec_valid),
    .rec_data       (rec_data),
    .rec_al_ptr     (rec_al_ptr),
    .flush_valid    (flush_valid),
    .flush_head_ptr (flush_head_ptr),
    .flush_tail_ptr (flush_tail_ptr),
    .rpl_ready      (rpl_ready),
    .rpl_valid      (rpl_valid),
    .rpl_data       (rpl_data),
    .full           (full),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Every accepted replay must match the oldest expected payload.
  always @(negedge clk) begin
    if (rst_n && rpl_ready && !stall && !clear) begin
      for (int l = 0; l < 2; l++) begin
        if (rpl_valid[l]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL replay_unexpected lane %0d got %h want none",
                     l, rpl_data[l*64 +: 64]);
          end else begin
            chk("replay_data", rpl_data[l*64 +: 64], exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rec2(input logic [1:0] m,
                      input logic [5:0] p0, input logic [63:0] d0,
                      input logic [5:0] p1, input logic [63:0] d1);
    rec_valid  = m;
    rec_data   = {d1, d0};
    rec_al_ptr = {p1, p0};
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 20 && count != 0; i++) step();
    chk(name, 64'(count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    clear = 1'b0;
    rec_valid = '0;
    rec_data = '0;
    rec_al_ptr = '0;
    flush_valid = 1'b0;
    flush_head_ptr = '0;
    flush_tail_ptr = '0;
    rpl_ready = 1'b1;
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(rpl_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // single record, latency REPLAY_DELAY+1
    rec2(2'b01, 6'd3, 64'hA, 6'd0, 64'd0);
    exp_q.push_back(64'hA);
    step();
    rec_valid = '0;
    chk("t1_c1_count", 64'(count), 64'd1);
    chk("t1_c1_valid", 64'(rpl_valid), 64'd0);
    step();
    chk("t1_c2_valid", 64'(rpl_valid), 64'd0);
    step();
    chk("t1_c3_valid", 64'(rpl_valid), 64'd1);
    chk("t1_c3_data", rpl_data[63:0], 64'hA);
    step();
    chk("t1_c4_count", 64'(count), 64'd0);

    // ordering across two record cycles
    rec2(2'b11, 6'd4, 64'hB0, 6'd5, 64'hB1);
    exp_q.push_back(64'hB0);
    exp_q.push_back(64'hB1);
    step();
    rec2(2'b01, 6'd6, 64'hB2, 6'd0, 64'd0);
    exp_q.push_back(64'hB2);
    step();
    rec_valid = '0;
    step();
    chk("t2_c3_valid", 64'(rpl_valid), 64'd3);
    step();
    chk("t2_c4_valid", 64'(rpl_valid), 64'd1);
    chk("t2_c4_data", rpl_data[63:0], 64'hB2);
    step();
    chk("t2_c5_count", 64'(count), 64'd0);

    // fill, full flag and overflow drop
    rpl_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rec2(2'b11, 6'(10 + 2*i), 64'hF00 + 64'(2*i),
                  6'(11 + 2*i), 64'hF00 + 64'(2*i + 1));
      exp_q.push_back(64'hF00 + 64'(2*i));
      exp_q.push_back(64'hF00 + 64'(2*i + 1));
      step();
    end
    rec_valid = '0;
    chk("t3_count6", 64'(count), 64'd6);
    chk("t3_full6", 64'(full), 64'd0);
    rec2(2'b01, 6'd16, 64'hF06, 6'd0, 64'd0);
    exp_q.push_back(64'hF06);
    step();
    chk("t3_count7", 64'(count), 64'd7);
    chk("t3_full7", 64'(full), 64'd1);
    chk("t3_ovf_pre", 64'(overflow), 64'd0);
    rec2(2'b11, 6'd17, 64'hF07, 6'd18, 64'hF08);
    exp_q.push_back(64'hF07);
    step();
    rec_valid = '0;
    chk("t3_count8", 64'(count), 64'd8);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_full8", 64'(full), 64'd1);
    rpl_ready = 1'b1;
    wait_empty("t3_drain");
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // selective flush across pointer wrap
    rec2(2'b11, 6'd60, 64'hD0, 6'd62, 64'hD1);
    exp_q.push_back(64'hD0);
    step();
    rec2(2'b01, 6'd1, 64'hD2, 6'd0, 64'd0);
    step();
    rec_valid = '0;
    flush_valid = 1'b1;
    flush_head_ptr = 6'd62;
    flush_tail_ptr = 6'd2;
    step();
    flush_valid = 1'b0;
    wait_empty("t4_drain");

    // stall freezes aging; flush under stall still kills
    rec2(2'b11, 6'd20, 64'hE0, 6'd21, 64'hE1);
    exp_q.push_back(64'hE0);
    step();
    rec_valid = '0;
    stall = 1'b1;
    step();
    flush_valid = 1'b1;
    flush_head_ptr = 6'd21;
    flush_tail_ptr = 6'd22;
    step();
    flush_valid = 1'b0;
    step();
    stall = 1'b0;
    chk("t5_c4_count", 64'(count), 64'd2);
    chk("t5_c4_valid", 64'(rpl_valid), 64'd0);
    step();
    chk("t5_c5_valid", 64'(rpl_valid), 64'd0);
    step();
    chk("t5_c6_valid", 64'(rpl_valid), 64'd1);
    chk("t5_c6_data", rpl_data[63:0], 64'hE0);
    wait_empty("t5_drain");

    // clear dominates a same-cycle record
    rpl_ready = 1'b0;
    rec2(2'b11, 6'd30, 64'hC0, 6'd31, 64'hC1);
    step();
    rec2(2'b11, 6'd32, 64'hC2, 6'd33, 64'hC3);
    step();
    chk("t6_count4", 64'(count), 64'd4);
    clear = 1'b1;
    rec2(2'b01, 6'd34, 64'hC4, 6'd0, 64'd0);
    step();
    clear = 1'b0;
    rec_valid = '0;
    chk("t6_clr_count", 64'(count), 64'd0);
    chk("t6_clr_valid", 64'(rpl_valid), 64'd0);
    rpl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_replay", 64'(rpl_valid), 64'd0);
    end

    // async reset while a replay is presented
    rpl_ready = 1'b0;
    rec2(2'b01, 6'd40, 64'h6, 6'd0, 64'd0);
    step();
    rec_valid = '0;
    step();
    step();
    chk("t7_pre_valid", 64'(rpl_valid), 64'd1);
    chk("t7_pre_data", rpl_data[63:0], 64'h6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 64'(rpl_valid), 64'd0);
    chk("t7_rst_count", 64'(count), 64'd0);
    chk("t7_rst_ovf", 64'(overflow), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t7_post_count", 64'(count), 64'd0);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
